// File: rtl/tk1_spi_master_if.sv
// Register-side strobes and flash pins of the tk1 SPI master, bundled as one port.
// The master modport is the SPI master's own view; slave is the register file plus flash side.
interface tk1_spi_master_if;
  logic       spi_enable;
  logic       spi_enable_vld;
  logic [7:0] spi_tx_data;
  logic       spi_tx_data_vld;
  logic       spi_start;
  logic       spi_ready;
  logic [7:0] spi_rx_data;
  logic       spi_ss;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  spi_enable,
    input  spi_enable_vld,
    input  spi_tx_data,
    input  spi_tx_data_vld,
    input  spi_start,
    input  spi_miso,
    output spi_ready,
    output spi_rx_data,
    output spi_ss,
    output spi_sck,
    output spi_mosi
  );

  modport slave (
    output spi_enable,
    output spi_enable_vld,
    output spi_tx_data,
    output spi_tx_data_vld,
    output spi_start,
    output spi_miso,
    input  spi_ready,
    input  spi_rx_data,
    input  spi_ss,
    input  spi_sck,
    input  spi_mosi
  );
endinterface

// File: rtl/tk1_spi_master.sv
// Byte-oriented SPI mode 0 master for the tk1 flash pins; firmware owns chip select
// and issues one byte per start strobe, MSB first.
module tk1_spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  tk1_spi_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCK_LO,
    SCK_HI
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_d;
  logic       enable_reg;
  logic [7:0] tx_reg;
  logic [7:0] shift_reg, shift_d;
  logic [7:0] rx_shift, rx_shift_d;
  logic [7:0] rx_data, rx_data_d;
  logic [2:0] bit_ctr, bit_d;
  logic [7:0] div_ctr, div_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       div_done;

  assign div_done = (div_ctr == DIV_LAST);

  always_comb begin
    state_d    = state;
    shift_d    = shift_reg;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    bit_d      = bit_ctr;
    div_d      = div_ctr;

    unique case (state)
      IDLE: begin
        if (bus.spi_start) begin
          shift_d = tx_reg;
          bit_d   = '0;
          div_d   = '0;
          state_d = SCK_LO;
        end
      end
      SCK_LO: begin
        if (div_done) begin
          div_d      = '0;
          rx_shift_d = {rx_shift[6:0], bus.spi_miso};
          state_d    = SCK_HI;
        end else begin
          div_d = div_ctr + 8'd1;
        end
      end
      SCK_HI: begin
        if (div_done) begin
          div_d = '0;
          if (bit_ctr == 3'd7) begin
            rx_data_d = rx_shift;
            state_d   = IDLE;
          end else begin
            shift_d = {shift_reg[6:0], 1'b0};
            bit_d   = bit_ctr + 3'd1;
            state_d = SCK_LO;
          end
        end else begin
          div_d = div_ctr + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they switch on the same edge as the FSM.
    sck_d  = (state_d == SCK_HI);
    mosi_d = (state_d == IDLE) ? 1'b0 : shift_d[7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      enable_reg <= 1'b0;
      tx_reg     <= '0;
      shift_reg  <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      bit_ctr    <= '0;
      div_ctr    <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      rx_shift  <= rx_shift_d;
      rx_data   <= rx_data_d;
      bit_ctr   <= bit_d;
      div_ctr   <= div_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      if (bus.spi_enable_vld) begin
        enable_reg <= bus.spi_enable;
      end
      // A start in the same cycle already latched the old value into shift_d.
      if (bus.spi_tx_data_vld && (state == IDLE)) begin
        tx_reg <= bus.spi_tx_data;
      end
    end
  end

  assign bus.spi_ready   = (state == IDLE);
  assign bus.spi_rx_data = rx_data;
  assign bus.spi_ss      = ~enable_reg;
  assign bus.spi_sck     = sck_q;
  assign bus.spi_mosi    = mosi_q;

endmodule
